// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state type and
// the counter sizing helper.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Wide enough to hold WIDTH itself, so the final increment never wraps.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder: abc_i[0]=A bit, abc_i[1]=B bit, abc_i[2]=carry in.
module full_adder (
  input  logic [2:0] abc_i,
  output logic       sum_o,
  output logic       carry_o
);

  assign sum_o   = ^abc_i;
  assign carry_o = (abc_i[0] & abc_i[1]) | (abc_i[2] & (abc_i[0] ^ abc_i[1]));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: {cout_o,sum_o} = a + b + cin, one bit per clock, LSB first,
// through a single full_adder. Results are published only on entry to DONE.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  localparam int unsigned    CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic [WIDTH:0]   res_ext;
  logic             fa_sum, fa_carry;

  full_adder u_fa (
    .abc_i  ({carry_q, b_q[0], a_q[0]}),
    .sum_o  (fa_sum),
    .carry_o(fa_carry)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ready_o = 1'b0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    // Extended by one bit so the MSB-side shift also works for WIDTH=1.
    res_ext = {fa_sum, res_q};

    unique case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (start_i) begin
          state_d = ADD;
          a_d     = a_i;
          b_d     = b_i;
          carry_d = cin_i;
          cnt_d   = '0;
        end
      end
      ADD: begin
        busy_o  = 1'b1;
        res_d   = res_ext[WIDTH:1];
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_carry;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          sum_d   = res_ext[WIDTH:1];
          cout_d  = fa_carry;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (rst_i) begin
      ready_o = 1'b1;
      busy_o  = 1'b0;
      done_o  = 1'b0;
    end
  end

  assign sum_o  = sum_q;
  assign cout_o = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomised self-checking bench for serial_adder_ctrl at WIDTH = 8, 13 and 1,
// compared against plain integer addition.
module tb_serial_adder_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  start;
  logic [31:0] a, b;
  logic        cin;
  logic [2:0]  ready, busy, done, cout;
  logic [7:0]  sum8;
  logic [12:0] sum13;
  logic [0:0]  sum1;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start[0]), .a_i(a[7:0]), .b_i(b[7:0]),
    .cin_i(cin), .ready_o(ready[0]), .busy_o(busy[0]), .done_o(done[0]),
    .sum_o(sum8), .cout_o(cout[0])
  );

  serial_adder_ctrl #(.WIDTH(13)) u_dut13 (
    .clk_i(clk), .rst_i(rst), .start_i(start[1]), .a_i(a[12:0]), .b_i(b[12:0]),
    .cin_i(cin), .ready_o(ready[1]), .busy_o(busy[1]), .done_o(done[1]),
    .sum_o(sum13), .cout_o(cout[1])
  );

  serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start[2]), .a_i(a[0:0]), .b_i(b[0:0]),
    .cin_i(cin), .ready_o(ready[2]), .busy_o(busy[2]), .done_o(done[2]),
    .sum_o(sum1), .cout_o(cout[2])
  );

  function automatic int unsigned width_of(input int sel);
    case (sel)
      0:       return 8;
      1:       return 13;
      default: return 1;
    endcase
  endfunction

  // {cout,sum} of the selected instance as one number.
  function automatic logic [63:0] result_of(input int sel);
    logic [63:0] s;
    case (sel)
      0:       s = 64'(sum8);
      1:       s = 64'(sum13);
      default: s = 64'(sum1);
    endcase
    return s | (64'(cout[sel]) << width_of(sel));
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation on instance sel, accepted at the end of the current cycle.
  // With scramble set, start and operands are disturbed every cycle after acceptance.
  task automatic run_op(input int sel, input logic [31:0] av, input logic [31:0] bv,
                        input logic ci, input bit scramble);
    int unsigned w;
    int unsigned n;
    logic [63:0] mask, expv, prev;
    w    = width_of(sel);
    mask = (64'd1 << w) - 64'd1;
    expv = (64'(av) & mask) + (64'(bv) & mask) + 64'(ci);
    prev = result_of(sel);
    chk("ready_before", 64'(ready[sel]), 64'd1);
    a = av; b = bv; cin = ci; start[sel] = 1'b1;
    tick();
    start = '0;
    n = 1;
    while (!done[sel] && n <= w + 3) begin
      chk("busy", 64'(busy[sel]), 64'd1);
      chk("ready_low", 64'(ready[sel]), 64'd0);
      chk("hold_result", result_of(sel), prev);
      if (scramble) begin
        start[sel] = 1'b1;
        a = $urandom; b = $urandom; cin = 1'($urandom);
      end
      tick();
      n++;
    end
    chk("latency", 64'(n), 64'(w + 1));
    chk("done", 64'(done[sel]), 64'd1);
    chk("result", result_of(sel), expv);
    if (scramble) start[sel] = 1'b1;
    tick();
    start = '0;
    chk("ready_after", 64'(ready[sel]), 64'd1);
    chk("done_single", 64'(done[sel]), 64'd0);
    chk("busy_after", 64'(busy[sel]), 64'd0);
    chk("result_hold", result_of(sel), expv);
  endtask

  initial begin
    rst = 1'b1; start = '1; a = '1; b = '1; cin = 1'b1;
    tick();
    tick();
    // Reset wins over start on the same edge.
    for (int s = 0; s < 3; s++) begin
      chk("rst_ready", 64'(ready[s]), 64'd1);
      chk("rst_busy", 64'(busy[s]), 64'd0);
      chk("rst_done", 64'(done[s]), 64'd0);
      chk("rst_result", result_of(s), 64'd0);
    end
    start = '0;
    rst = 1'b0;
    tick();

    run_op(0, 32'hFF, 32'h01, 1'b0, 1'b0);
    run_op(0, 32'hA5, 32'h5A, 1'b1, 1'b0);
    run_op(0, 32'h12, 32'h34, 1'b0, 1'b0);
    chk("b2b_sum", result_of(0), 64'h046);
    run_op(0, 32'h3C, 32'h81, 1'b1, 1'b1);
    run_op(1, 32'h1FFF, 32'h0001, 1'b0, 1'b1);
    run_op(2, 32'h1, 32'h1, 1'b1, 1'b0);
    run_op(2, 32'h0, 32'h0, 1'b0, 1'b0);
    run_op(2, 32'h1, 32'h0, 1'b1, 1'b1);
    run_op(0, 32'h77, 32'h11, 1'b0, 1'b0);

    // Abort in ADD cycle 4: no done pulse, cleared result, idle next cycle.
    a = 32'hC3; b = 32'h5A; cin = 1'b1; start[0] = 1'b1;
    tick();
    start = '0;
    for (int c = 1; c < 4; c++) tick();
    chk("abort_busy", 64'(busy[0]), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_ready", 64'(ready[0]), 64'd1);
    chk("abort_busy_low", 64'(busy[0]), 64'd0);
    chk("abort_result", result_of(0), 64'd0);
    for (int c = 0; c < 12; c++) begin
      chk("abort_no_done", 64'(done[0]), 64'd0);
      tick();
    end

    for (int i = 0; i < 1000; i++)
      run_op(0, $urandom, $urandom, 1'($urandom), bit'($urandom_range(0, 3) == 0));
    for (int i = 0; i < 1000; i++)
      run_op(1, $urandom, $urandom, 1'($urandom), bit'($urandom_range(0, 3) == 0));
    for (int i = 0; i < 50; i++)
      run_op(2, $urandom, $urandom, 1'($urandom), bit'($urandom_range(0, 1)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, setting the operand width in bits; legal range 1..32.
REQ-002 The block SHALL have port clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port start_i  input  1  request to begin an addition; sampled only while ready_o=1.
REQ-005 The block SHALL have port a_i  input  WIDTH  operand A; captured on the accepting edge.
REQ-006 The block SHALL have port b_i  input  WIDTH  operand B; captured on the accepting edge.
REQ-007 The block SHALL have port cin_i  input  1  carry-in; captured on the accepting edge.
REQ-008 The block SHALL have port ready_o  output  1  high only in IDLE.
REQ-009 The block SHALL have port busy_o  output  1  high only in ADD.
REQ-010 The block SHALL have port done_o  output  1  one-cycle pulse, high only in DONE.
REQ-011 The block SHALL have port sum_o  output  WIDTH  result of the last completed addition.
REQ-012 The block SHALL have port cout_o  output  1  carry-out of the last completed addition.

Function
REQ-013 The block SHALL compute {cout_o,sum_o} = a_i + b_i + cin_i bit-serially, one bit per clock, LSB first, through a single full_adder instance.
REQ-014 The FSM SHALL have exactly three states: IDLE, ADD and DONE.
REQ-015 IDLE SHALL go to ADD on the edge where start_i=1; on that edge it SHALL capture a_i and b_i into shift registers, load cin_i into the carry flop and clear the bit counter.
REQ-016 In each ADD cycle the full_adder SHALL receive {carry flop, B shift LSB, A shift LSB}.
REQ-017 On each ADD edge the block SHALL shift the adder sum bit into the result register MSB-side, shift the A/B registers right by one, store the adder carry into the carry flop, and increment the counter.
REQ-018 ADD SHALL go to DONE on the edge where the counter equals WIDTH-1, i.e. after exactly WIDTH ADD cycles.
REQ-019 DONE SHALL last one cycle and then go to IDLE unconditionally.
REQ-020 Latency SHALL be fixed: with start accepted at the end of cycle 0, ADD occupies cycles 1..WIDTH, done_o=1 in cycle WIDTH+1, and ready_o=1 again in cycle WIDTH+2.
REQ-021 sum_o and cout_o SHALL update only on the edge entering DONE.
REQ-022 sum_o and cout_o SHALL hold that value until the next DONE or reset, and intermediate shift state SHALL never be visible on them.
REQ-023 start_i SHALL be ignored in ADD and DONE, and operand changes after acceptance SHALL NOT affect the result.
REQ-024 The counter SHALL be $clog2(WIDTH+1) bits wide and SHALL never wrap during an operation.
REQ-025 With WIDTH=1, ADD SHALL last one cycle and done_o SHALL be high in cycle 2.
REQ-026 Back-to-back operations SHALL be possible with one IDLE cycle between DONE and the next acceptance.

Reset
REQ-027 While rst_i=1 at an edge, the FSM SHALL go to IDLE and the counter, carry flop, shift registers, sum_o and cout_o SHALL clear to 0.
REQ-028 In reset, ready_o SHALL be 1 and busy_o and done_o SHALL be 0.
REQ-029 Reset asserted mid-ADD SHALL abort the operation with no done_o pulse, and sum_o SHALL read 0 afterwards.
REQ-030 rst_i SHALL take priority over start_i on the same edge.

Structure
REQ-031 A shared package serial_adder_pkg SHALL hold the state enum (IDLE, ADD, DONE) and the counter-width constant function.
REQ-032 The single sub-module SHALL be the existing full_adder, with abc_i[0]=A bit, abc_i[1]=B bit and abc_i[2]=carry flop; no other arithmetic logic is permitted.

Verification
REQ-033 The bench SHALL drive WIDTH=8, a=8'hFF, b=8'h01, cin=0 -> sum_o=8'h00, cout_o=1, done_o high in cycle 9 only.
REQ-034 The bench SHALL drive a=8'hA5, b=8'h5A, cin=1 -> sum_o=8'h00, cout_o=1; then a=8'h12, b=8'h34, cin=0 back-to-back -> sum_o=8'h46, cout_o=0.
REQ-035 The bench SHALL pulse start_i and change a_i/b_i every cycle during ADD -> result equals the captured operands only, and no second operation starts.
REQ-036 The bench SHALL assert rst_i in ADD cycle 4 -> IDLE next cycle, ready_o=1, sum_o=0, and no done_o pulse.
REQ-037 The bench SHALL drive WIDTH=1, a=1, b=1, cin=1 -> sum_o=1, cout_o=1, done_o in cycle 2.
REQ-038 The bench SHALL run 1000 random operands and cin at WIDTH=8 and WIDTH=13 -> {cout_o,sum_o} matches a model sum each time, with fixed latency WIDTH+1.
